// File: rtl/pixel_scan_writer.sv
// pixel_scan_writer: frame-fill initiator.
// Walks a WIDTH x HEIGHT frame in raster order, presents each (x, y) to the
// palette, captures the colour LAT clocks later and writes it to the
// framebuffer over a valid/ready port. One start pulse fills one frame.
// Optional feature: define FRAME_CHECKSUM_EN to add the 32-bit frame
// checksum output (rotate-left-and-xor over every accepted write).
module pixel_scan_writer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int LAT    = 1,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [31:0]       px_x,
    output logic [31:0]       px_y,
    input  logic [23:0]       color,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    input  logic              wr_ready
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    // Down-counter width for the palette wait; at least one bit even when
    // the palette is combinational so the declaration stays legal.
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LAT > 0) ? (LAT - 1) : 0);
    localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [15:0]      x_cnt;
    logic [15:0]      y_cnt;
    logic [CNT_W-1:0] lat_cnt;
    logic             accept;
    logic             last_pixel;

    assign accept     = (state == S_WRITE) && wr_ready;
    assign last_pixel = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

    // Coordinates go straight from the raster counters; upper half is zero.
    assign px_x = {16'd0, x_cnt};
    assign px_y = {16'd0, y_cnt};

    // State register; reset forces IDLE at the same edge, abandoning a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: ISSUE skips WAIT entirely for a zero-latency palette.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (LAT > 0) begin
                    next_state = S_WAIT;
                end else begin
                    next_state = S_WRITE;
                end
            end
            S_WAIT: begin
                if (lat_cnt == '0) begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_ready) begin
                    next_state = last_pixel ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Status and write-valid outputs decoded purely from the current state.
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        wr_en = 1'b0;
        case (state)
            S_ISSUE: busy = 1'b1;
            S_WAIT:  busy = 1'b1;
            S_WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: begin
                busy  = 1'b0;
            end
        endcase
    end

    // Raster counters, write address and palette wait counter. The address
    // is a running count rather than y*WIDTH+x so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            wr_addr <= '0;
            lat_cnt <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                x_cnt   <= '0;
                y_cnt   <= '0;
                wr_addr <= '0;
            end
            if (state == S_ISSUE) begin
                lat_cnt <= CNT_LOAD;
            end else if (state == S_WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - CNT_W'(1);
            end
            if (accept) begin
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + 16'd1;
                end else begin
                    x_cnt <= x_cnt + 16'd1;
                end
                wr_addr <= wr_addr + ADDR_W'(1);
            end
        end
    end

    // Colour capture at the edge entering WRITE; held through any stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_data <= '0;
        end else if (state != S_WRITE && next_state == S_WRITE) begin
            wr_data <= color;
        end
    end

`ifdef FRAME_CHECKSUM_EN
    // Frame checksum: cleared when a frame starts, folded on every accepted write.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (state == S_IDLE && start) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= {checksum[30:0], checksum[31]} ^ {8'h00, wr_data};
        end
    end
`endif

endmodule
